// File: rtl/alu_mult_sequencer_if.sv
// rtl/alu_mult_sequencer_if.sv - request/result handshake and shared-ALU bus of the multiply sequencer
interface alu_mult_sequencer_if #(
    parameter int WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [2:0]         alu_cmd;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_carryout;

    modport master (
        output in_valid, multiplicand, multiplier, out_ready, alu_result, alu_carryout,
        input  in_ready, out_valid, product, alu_a, alu_b, alu_cmd
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, out_ready, alu_result, alu_carryout,
        output in_ready, out_valid, product, alu_a, alu_b, alu_cmd
    );
endinterface

// File: rtl/alu_mult_sequencer.sv
// rtl/alu_mult_sequencer.sv - shift-and-add multiplier driving the shared ALU; optional ALU_MULT_EARLY_EXIT_EN
module alu_mult_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic                 clk,
    input logic                 reset,
    alu_mult_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [CNT_W-1:0]   cnt;

    logic               carry;
    logic [WIDTH-1:0]   sum;
    logic [2*WIDTH-1:0] shifted;
    logic [2*WIDTH-1:0] next_hl;
    logic               last_iter;
    logic               exit_now;

    // The ALU result is only taken when the current multiplier bit is set.
    assign carry     = lo[0] ? bus.alu_carryout : 1'b0;
    assign sum       = lo[0] ? bus.alu_result : hi;
    assign shifted   = {carry, sum, lo[WIDTH-1:1]};
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef ALU_MULT_EARLY_EXIT_EN
    logic [CNT_W-1:0]   done_k;
    logic [WIDTH-1:0]   rem_mask;
    logic [2*WIDTH-1:0] exit_val;

    assign done_k   = cnt + CNT_W'(1);
    assign rem_mask = {WIDTH{1'b1}} >> done_k;
    assign exit_now = !last_iter && ((shifted[WIDTH-1:0] & rem_mask) == '0);
    // Remaining iterations would be pure shifts; apply them in one step.
    assign exit_val = shifted >> (CNT_W'(WIDTH) - done_k);
    assign next_hl  = exit_now ? exit_val : shifted;
`else
    assign exit_now = 1'b0;
    assign next_hl  = shifted;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nx = ITER;
                end
            end
            ITER: begin
                if (last_iter || exit_now) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand <= bus.multiplicand;
                        hi    <= '0;
                        lo    <= bus.multiplier;
                        cnt   <= '0;
                    end
                end
                ITER: begin
                    {hi, lo} <= next_hl;
                    cnt      <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.product = (state == DONE) ? {hi, lo} : '0;
    assign bus.alu_a   = hi;
    assign bus.alu_b   = mcand;
    assign bus.alu_cmd = 3'd0;
endmodule

// File: tb/tb_alu_mult_sequencer.sv
// tb/tb_alu_mult_sequencer.sv - directed self-checking bench for alu_mult_sequencer
module tb_alu_mult_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc;
    logic [63:0] held;

    alu_mult_sequencer_if #(.WIDTH(32)) bus ();

    alu_mult_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference 32-bit ADD ALU
    assign {bus.alu_carryout, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic [31:0] a, input logic [31:0] b, input bit keep);
        @(negedge clk);
        check("accept_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid     = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        @(posedge clk);
        #1;
        if (!keep) bus.in_valid = 1'b0;
        bus.multiplicand = 32'hDEAD_BEEF;
        bus.multiplier   = 32'hCAFE_F00D;
    endtask

    task automatic wait_valid(output int cycle);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            check("alu_cmd", 64'(bus.alu_cmd), 64'd0);
            @(posedge clk);
            #1;
            n++;
        end
        cycle = n + 1;
    endtask

    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp_p, input int exp_cyc);
        int c;
        start_req(a, b, 1'b0);
        wait_valid(c);
        check({tag, "_latency"}, 64'(c), 64'(exp_cyc));
        check({tag, "_product"}, bus.product, exp_p);
        @(posedge clk);
        #1;
        check({tag, "_valid_one_cycle"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_ready_after"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.out_ready    = 1'b1;
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_product", bus.product, 64'd0);
        check("rst_alu_a", 64'(bus.alu_a), 64'd0);
        check("rst_alu_b", 64'(bus.alu_b), 64'd0);
        check("rst_alu_cmd", 64'(bus.alu_cmd), 64'd0);
        @(negedge clk);
        reset = 1'b0;

`ifdef ALU_MULT_EARLY_EXIT_EN
        run_mult("m3x5", 32'd3, 32'd5, 64'd15, 4);
`else
        run_mult("m3x5", 32'd3, 32'd5, 64'd15, 33);
`endif
        run_mult("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);

        // Result held under backpressure; busy-time requests ignored
        bus.out_ready = 1'b0;
        start_req(32'h8000_0000, 32'd2, 1'b0);
        wait_valid(cyc);
`ifdef ALU_MULT_EARLY_EXIT_EN
        check("hold_latency", 64'(cyc), 64'd3);
`else
        check("hold_latency", 64'(cyc), 64'd33);
`endif
        check("hold_product", bus.product, 64'h0000_0001_0000_0000);
        held = bus.product;
        bus.in_valid     = 1'b1;
        bus.multiplicand = 32'd9;
        bus.multiplier   = 32'd9;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) bus.in_valid = 1'b0;
            check("hold_stable", bus.product, held);
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_valid", 64'(bus.out_valid), 64'd0);
        check("hold_release_ready", 64'(bus.in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("hold_no_queued", 64'(bus.in_ready), 64'd1);
        check("hold_no_queued_valid", 64'(bus.out_valid), 64'd0);

        // Reset while a multiply is in flight
        bus.out_ready = 1'b0;
        start_req(32'd12345, 32'd678, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_product", bus.product, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        check("postrst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef ALU_MULT_EARLY_EXIT_EN
        run_mult("m7x6", 32'd7, 32'd6, 64'd42, 4);
`else
        run_mult("m7x6", 32'd7, 32'd6, 64'd42, 33);
`endif

        // Back-to-back with in_valid held high
        start_req(32'd2, 32'd3, 1'b1);
        bus.multiplicand = 32'd4;
        bus.multiplier   = 32'd5;
        wait_valid(cyc);
`ifdef ALU_MULT_EARLY_EXIT_EN
        check("b2b1_latency", 64'(cyc), 64'd3);
`else
        check("b2b1_latency", 64'(cyc), 64'd33);
`endif
        check("b2b1_product", bus.product, 64'd6);
        @(posedge clk);
        #1;
        check("b2b_idle_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        check("b2b_accepted", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;
        wait_valid(cyc);
`ifdef ALU_MULT_EARLY_EXIT_EN
        check("b2b2_latency", 64'(cyc), 64'd4);
`else
        check("b2b2_latency", 64'(cyc), 64'd33);
`endif
        check("b2b2_product", bus.product, 64'd20);
        @(posedge clk);
        #1;

`ifdef ALU_MULT_EARLY_EXIT_EN
        run_mult("ee7x2", 32'd7, 32'd2, 64'd14, 3);
        run_mult("ee9x0", 32'd9, 32'd0, 64'd0, 2);
        run_mult("ee1xmsb", 32'd1, 32'h8000_0000, 64'h0000_0000_8000_0000, 33);
`else
        run_mult("m9x0", 32'd9, 32'd0, 64'd0, 33);
        run_mult("m1xmsb", 32'd1, 32'h8000_0000, 64'h0000_0000_8000_0000, 33);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mult_sequencer.md
Name: alu_mult_sequencer

Overview:
- Multi-cycle controller that performs a 32x32 -> 64-bit unsigned multiply by shift-and-add.
- Sequences the existing 32-bit combinational ALU through an external command/operand interface; it has no adder of its own.
- Sits between the instruction/execute control and the shared ALU. Uses a valid/ready handshake on both the request side and the result side.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH. Only 32 is verified.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request (IDLE only).
- multiplicand  input  32  operand A.
- multiplier  input  32  operand B.
- out_valid  output  1  product available.
- out_ready  input  1  consumer accepts product.
- product  output  64  result; stable while out_valid=1.
- alu_a  output  32  ALU operandA, driven from the hi accumulator.
- alu_b  output  32  ALU operandB, driven from the multiplicand register.
- alu_cmd  output  3  ALU command; constant 3'd0 (ADD).
- alu_result  input  32  ALU result.
- alu_carryout  input  1  ALU carryout.

Behaviour:
- Registers:
  - mcand (32): multiplicand.
  - hi (32) and lo (32): accumulator / multiplier pair.
  - cnt (CNT_W): iteration counter.
  - state: IDLE, ITER or DONE.
- Reset (async): state=IDLE, hi=lo=mcand=0, cnt=0. Outputs: in_ready=1, out_valid=0, product=0, alu_a=0, alu_b=0, alu_cmd=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: mcand<=multiplicand, hi<=0, lo<=multiplier, cnt<=0, go to ITER.
- ITER (in_ready=0):
  - ALU is combinational: alu_a=hi, alu_b=mcand, alu_cmd=ADD.
  - If lo[0]=1: {c,s}={alu_carryout,alu_result}; else {c,s}={0,hi}.
  - Update {hi,lo} <= {c,s,lo[31:1]} (right shift of the 65-bit value).
  - cnt<=cnt+1. When cnt==31 in this cycle, go to DONE.
  - Exactly 32 ITER cycles.
- DONE:
  - out_valid=1, product={hi,lo}, held unchanged until out_ready=1.
  - On out_valid&&out_ready: go to IDLE; in_ready=1 the next cycle.
- Latency: accept edge = cycle 0; ITER cycles 1..32; out_valid first high in cycle 33.
- in_valid while busy (ITER/DONE) is ignored. Inputs are not sampled and no request is queued.
- Changes on multiplicand/multiplier after acceptance have no effect.
- Reset asserted mid-ITER or mid-DONE: immediate return to the reset values. The in-flight product is discarded and out_valid never pulses.
- Overflow is impossible: the 65-bit {c,hi,lo} holds any partial sum. The ALU overflow/zero outputs are unused.
- Throughput: one product per 34 cycles minimum (accept, 32 ITER, DONE with out_ready=1).

Optional Feature:
- Macro: ALU_MULT_EARLY_EXIT_EN.
- Defined:
  - At the end of each ITER cycle, let k = cnt+1 = iterations done.
  - If the unconsumed multiplier bits (post-shift lo[31-k:0]) are all zero and k<32, go to DONE.
  - On that same edge, load {hi,lo} with the 64-bit post-shift value shifted right by 32-k. This equals the skipped no-add iterations.
  - The product is identical to the non-early-exit result.
  - Cycles: multiplier=0 -> 1 ITER cycle (valid in cycle 2); multiplier=2 -> 2 ITER cycles (valid in cycle 3); multiplier with bit31=1 -> 32 ITER cycles.
- Undefined: always 32 ITER cycles. No barrel-shift logic is synthesised.

Test Plan:
- 3 x 5, out_ready=1 -> out_valid high in cycle 33 for exactly 1 cycle; product=64'h0000_0000_0000_000F; alu_cmd=0 throughout.
- 32'hFFFFFFFF x 32'hFFFFFFFF -> product=64'hFFFF_FFFE_0000_0001; alu_carryout is consumed, with no lost carry.
- 32'h8000_0000 x 2 with out_ready=0 for 10 cycles after out_valid -> product=64'h0000_0001_0000_0000 held stable; in_ready=0 until the handshake; a second in_valid during the wait is ignored.
- Start 12345 x 678, assert reset at cycle 15 for 1 cycle -> out_valid=0, in_ready=1, product=0. A new request 7 x 6 then yields 42 in cycle 33 relative to its own acceptance.
- Back-to-back: 2 x 3, then 4 x 5 with in_valid held high -> products 6 and 20; second accept one cycle after the first result's handshake.
- With ALU_MULT_EARLY_EXIT_EN: 7 x 2 -> 14, out_valid in cycle 3; 9 x 0 -> 0, out_valid in cycle 2; 1 x 32'h8000_0000 -> 64'h0000_0000_8000_0000, out_valid in cycle 33.
